// File: rtl/reorder_buffer_mw_pkg.sv
// Shared types and default widths for the multi-wide reorder buffer.
// Exception causes follow the machine-mode cause encoding used by the CSR file.
package reorder_buffer_mw_pkg;

    localparam int REGISTER_WIDTH   = 5;
    localparam int DATA_WIDTH       = 32;
    localparam int ADDR_WIDTH       = 32;
    localparam int ROB_ALLOC_WIDTH  = 2;
    localparam int ROB_COMMIT_WIDTH = 2;
    localparam int ROB_CPL_PORTS    = 2;

    typedef enum logic [3:0] {
        EXC_INSTR_MISALIGNED = 4'd0,
        EXC_INSTR_ACCESS     = 4'd1,
        EXC_ILLEGAL_INSTR    = 4'd2,
        EXC_BREAKPOINT       = 4'd3,
        EXC_LOAD_MISALIGNED  = 4'd4,
        EXC_LOAD_ACCESS      = 4'd5,
        EXC_STORE_MISALIGNED = 4'd6,
        EXC_STORE_ACCESS     = 4'd7,
        EXC_ECALL_U          = 4'd8,
        EXC_ECALL_M          = 4'd11
    } excpt_cause_t;

    typedef struct packed {
        logic                      busy;
        logic                      done;
        logic                      excp;
        logic                      wb;
        logic [REGISTER_WIDTH-1:0] reg_id;
        logic [DATA_WIDTH-1:0]     data;
        logic [ADDR_WIDTH-1:0]     pc;
        excpt_cause_t              cause;
        logic [ADDR_WIDTH-1:0]     tval;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_mw_sva.sv
// Protocol checks for the reorder buffer: contiguous dispatch lanes, bounded occupancy.
module reorder_buffer_mw_sva #(
    parameter int ALLOC_WIDTH = 2,
    parameter int ROB_ENTRIES = 16,
    parameter int CNT_W       = 5
) (
    input logic                   clk_i,
    input logic                   rst_i,
    input logic [ALLOC_WIDTH-1:0] alloc_valid_i,
    input logic [CNT_W-1:0]       count_i
);

    a_alloc_contig: assert property (@(posedge clk_i) disable iff (!rst_i)
        ((alloc_valid_i & (alloc_valid_i + ALLOC_WIDTH'(1))) == '0));

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_i)
        (count_i <= CNT_W'(ROB_ENTRIES)));

endmodule

// File: rtl/rob_commit_sel.sv
// Per-lane in-order retire eligibility and head-exception detect for the ROB.
module rob_commit_sel #(
    parameter int COMMIT_WIDTH = 2,
    parameter int CNT_W        = 5
) (
    input  logic [CNT_W-1:0]        count_i,
    input  logic [COMMIT_WIDTH-1:0] busy_i,
    input  logic [COMMIT_WIDTH-1:0] done_i,
    input  logic [COMMIT_WIDTH-1:0] excp_i,
    output logic [COMMIT_WIDTH-1:0] commit_o,
    output logic [CNT_W-1:0]        n_commit_o,
    output logic                    excp_head_o
);

    logic chain_s;

    // A lane retires only if every older lane in this cycle also retires.
    always_comb begin
        chain_s     = 1'b1;
        commit_o    = '0;
        n_commit_o  = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            commit_o[k] = chain_s && (CNT_W'(k) < count_i) &&
                          busy_i[k] && done_i[k] && !excp_i[k];
            chain_s     = commit_o[k];
            n_commit_o  = n_commit_o + CNT_W'(commit_o[k]);
        end
        excp_head_o = (count_i != '0) && busy_i[0] && done_i[0] && excp_i[0];
    end

endmodule

// File: rtl/reorder_buffer_mw.sv
// Multi-wide reorder buffer: ALLOC_WIDTH dispatch, CPL_PORTS writeback, COMMIT_WIDTH retire.
// Define ROB_BRANCH_FLUSH_EN to add branch-mispredict squash ports. Field widths come from the package.
module reorder_buffer_mw
    import reorder_buffer_mw_pkg::*;
#(
    parameter int ROB_ENTRIES     = 16,
    parameter int ROB_ENTRY_WIDTH = $clog2(ROB_ENTRIES),
    parameter int ALLOC_WIDTH     = ROB_ALLOC_WIDTH,
    parameter int COMMIT_WIDTH    = ROB_COMMIT_WIDTH,
    parameter int CPL_PORTS       = ROB_CPL_PORTS
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic [ALLOC_WIDTH-1:0]                          alloc_valid_i,
    output logic                                            alloc_ready_o,
    input  logic [ALLOC_WIDTH-1:0]                          alloc_is_wb_i,
    input  logic [ALLOC_WIDTH-1:0][REGISTER_WIDTH-1:0]      alloc_reg_id_i,
    input  logic [ALLOC_WIDTH-1:0][ADDR_WIDTH-1:0]          alloc_pc_i,
    input  logic [ALLOC_WIDTH-1:0]                          alloc_excp_i,
    input  excpt_cause_t [ALLOC_WIDTH-1:0]                  alloc_excp_cause_i,
    input  logic [ALLOC_WIDTH-1:0][ADDR_WIDTH-1:0]          alloc_excp_tval_i,
    output logic [ALLOC_WIDTH-1:0][ROB_ENTRY_WIDTH-1:0]     alloc_idx_o,
    input  logic [CPL_PORTS-1:0]                            cpl_valid_i,
    input  logic [CPL_PORTS-1:0][ROB_ENTRY_WIDTH-1:0]       cpl_idx_i,
    input  logic [CPL_PORTS-1:0][DATA_WIDTH-1:0]            cpl_data_i,
    input  logic [CPL_PORTS-1:0]                            cpl_excp_i,
    input  excpt_cause_t [CPL_PORTS-1:0]                    cpl_excp_cause_i,
    input  logic [CPL_PORTS-1:0][ADDR_WIDTH-1:0]            cpl_excp_tval_i,
`ifdef ROB_BRANCH_FLUSH_EN
    input  logic                                            bflush_valid_i,
    input  logic [ROB_ENTRY_WIDTH-1:0]                      bflush_idx_i,
`endif
    output logic [COMMIT_WIDTH-1:0]                         commit_valid_o,
    output logic [COMMIT_WIDTH-1:0]                         commit_is_wb_o,
    output logic [COMMIT_WIDTH-1:0][REGISTER_WIDTH-1:0]     commit_reg_id_o,
    output logic [COMMIT_WIDTH-1:0][DATA_WIDTH-1:0]         commit_data_o,
    output logic [COMMIT_WIDTH-1:0][ADDR_WIDTH-1:0]         commit_pc_o,
    output logic                                            excp_we_o,
    output excpt_cause_t                                    excp_cause_o,
    output logic [ADDR_WIDTH-1:0]                           excp_pc_o,
    output logic [ADDR_WIDTH-1:0]                           excp_tval_o,
    output logic                                            flush_o,
    output logic [ROB_ENTRY_WIDTH:0]                        count_o,
    output logic                                            empty_o
);

    localparam int EW    = ROB_ENTRY_WIDTH;
    localparam int CNT_W = ROB_ENTRY_WIDTH + 1;

    rob_entry_t        entries_q [ROB_ENTRIES];
    rob_entry_t        entries_d [ROB_ENTRIES];
    logic [EW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [COMMIT_WIDTH-1:0] lane_busy_s, lane_done_s, lane_excp_s, commit_s;
    logic [CNT_W-1:0]        n_commit_s, n_alloc_s;
    logic                    excp_head_s, alloc_ready_s, alloc_en_s, bflush_s;

`ifdef ROB_BRANCH_FLUSH_EN
    assign bflush_s = bflush_valid_i;
`else
    assign bflush_s = 1'b0;
`endif

    // Status of the slots that can retire this cycle, oldest first.
    always_comb begin
        lane_busy_s = '0;
        lane_done_s = '0;
        lane_excp_s = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            lane_busy_s[k] = entries_q[head_q + EW'(k)].busy;
            lane_done_s[k] = entries_q[head_q + EW'(k)].done;
            lane_excp_s[k] = entries_q[head_q + EW'(k)].excp;
        end
    end

    rob_commit_sel #(
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .CNT_W        (CNT_W)
    ) u_commit_sel (
        .count_i     (count_q),
        .busy_i      (lane_busy_s),
        .done_i      (lane_done_s),
        .excp_i      (lane_excp_s),
        .commit_o    (commit_s),
        .n_commit_o  (n_commit_s),
        .excp_head_o (excp_head_s)
    );

    // Dispatch handshake; free space is judged on registered occupancy only.
    always_comb begin
        alloc_ready_s = ((CNT_W'(ROB_ENTRIES) - count_q) >= CNT_W'(ALLOC_WIDTH)) && !excp_head_s;
        alloc_en_s    = alloc_ready_s && !bflush_s;
        n_alloc_s     = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            alloc_idx_o[i] = tail_q + EW'(i);
            if (alloc_en_s && alloc_valid_i[i]) begin
                n_alloc_s = n_alloc_s + CNT_W'(1);
            end else begin
                n_alloc_s = n_alloc_s;
            end
        end
    end

    // Retire and exception outputs, zeroed on idle lanes.
    always_comb begin
        commit_valid_o  = commit_s;
        commit_is_wb_o  = '0;
        commit_reg_id_o = '0;
        commit_data_o   = '0;
        commit_pc_o     = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (commit_s[k]) begin
                commit_is_wb_o[k]  = entries_q[head_q + EW'(k)].wb;
                commit_reg_id_o[k] = entries_q[head_q + EW'(k)].reg_id;
                commit_data_o[k]   = entries_q[head_q + EW'(k)].data;
                commit_pc_o[k]     = entries_q[head_q + EW'(k)].pc;
            end else begin
                commit_pc_o[k]     = '0;
            end
        end
        excp_we_o = excp_head_s;
        flush_o   = excp_head_s;
        if (excp_head_s) begin
            excp_cause_o = entries_q[head_q].cause;
            excp_pc_o    = entries_q[head_q].pc;
            excp_tval_o  = entries_q[head_q].tval;
        end else begin
            excp_cause_o = excpt_cause_t'(4'd0);
            excp_pc_o    = '0;
            excp_tval_o  = '0;
        end
        alloc_ready_o = alloc_ready_s;
        count_o       = count_q;
        empty_o       = (count_q == '0);
    end

    // Next state: retire, dispatch, writeback, then squash/flush override.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q + n_commit_s[EW-1:0];
        tail_d    = tail_q + n_alloc_s[EW-1:0];
        count_d   = count_q + n_alloc_s - n_commit_s;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (commit_s[k]) begin
                entries_d[head_q + EW'(k)].busy = 1'b0;
                entries_d[head_q + EW'(k)].done = 1'b0;
            end else begin
                entries_d[head_q + EW'(k)].busy = entries_d[head_q + EW'(k)].busy;
            end
        end
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            if (alloc_en_s && alloc_valid_i[i]) begin
                entries_d[alloc_idx_o[i]].busy   = 1'b1;
                entries_d[alloc_idx_o[i]].done   = alloc_excp_i[i];
                entries_d[alloc_idx_o[i]].excp   = alloc_excp_i[i];
                entries_d[alloc_idx_o[i]].wb     = alloc_is_wb_i[i];
                entries_d[alloc_idx_o[i]].reg_id = alloc_reg_id_i[i];
                entries_d[alloc_idx_o[i]].data   = '0;
                entries_d[alloc_idx_o[i]].pc     = alloc_pc_i[i];
                entries_d[alloc_idx_o[i]].cause  = alloc_excp_cause_i[i];
                entries_d[alloc_idx_o[i]].tval   = alloc_excp_tval_i[i];
            end else begin
                entries_d[alloc_idx_o[i]].busy   = entries_d[alloc_idx_o[i]].busy;
            end
        end
        // Later ports overwrite earlier ones; non-busy slots are stale and ignored.
        for (int p = 0; p < CPL_PORTS; p++) begin
            if (cpl_valid_i[p] && entries_q[cpl_idx_i[p]].busy) begin
                entries_d[cpl_idx_i[p]].data = cpl_data_i[p];
                entries_d[cpl_idx_i[p]].done = 1'b1;
                entries_d[cpl_idx_i[p]].excp = cpl_excp_i[p];
                if (cpl_excp_i[p]) begin
                    entries_d[cpl_idx_i[p]].cause = cpl_excp_cause_i[p];
                    entries_d[cpl_idx_i[p]].tval  = cpl_excp_tval_i[p];
                end else begin
                    entries_d[cpl_idx_i[p]].cause = entries_d[cpl_idx_i[p]].cause;
                end
            end else begin
                entries_d[cpl_idx_i[p]].done = entries_d[cpl_idx_i[p]].done;
            end
        end
`ifdef ROB_BRANCH_FLUSH_EN
        if (bflush_s) begin
            for (int s = 0; s < ROB_ENTRIES; s++) begin
                if (((EW'(s) - head_q) > (bflush_idx_i - head_q)) &&
                    (CNT_W'(EW'(s) - head_q) < count_q)) begin
                    entries_d[s].busy = 1'b0;
                    entries_d[s].done = 1'b0;
                    entries_d[s].excp = 1'b0;
                end else begin
                    entries_d[s].busy = entries_d[s].busy;
                end
            end
            tail_d  = bflush_idx_i + EW'(1);
            count_d = CNT_W'(bflush_idx_i - head_q + EW'(1)) - n_commit_s;
        end else begin
            tail_d  = tail_d;
        end
`endif
        if (excp_head_s) begin
            for (int s = 0; s < ROB_ENTRIES; s++) begin
                entries_d[s].busy = 1'b0;
                entries_d[s].done = 1'b0;
                entries_d[s].excp = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_d;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int s = 0; s < ROB_ENTRIES; s++) begin
                entries_q[s] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    reorder_buffer_mw_sva #(
        .ALLOC_WIDTH (ALLOC_WIDTH),
        .ROB_ENTRIES (ROB_ENTRIES),
        .CNT_W       (CNT_W)
    ) u_sva (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .alloc_valid_i (alloc_valid_i),
        .count_i       (count_q)
    );

endmodule

// File: tb/tb_reorder_buffer_mw.sv
// Directed bench for reorder_buffer_mw with 8 entries and 2-wide alloc/commit/completion.
module tb_reorder_buffer_mw;
    import reorder_buffer_mw_pkg::*;

    localparam int N  = 8;
    localparam int EW = 3;
    localparam int AW = 2;
    localparam int CW = 2;
    localparam int PW = 2;

    logic                                 clk_i;
    logic                                 rst_i;
    logic [AW-1:0]                        alloc_valid_i;
    logic                                 alloc_ready_o;
    logic [AW-1:0]                        alloc_is_wb_i;
    logic [AW-1:0][REGISTER_WIDTH-1:0]    alloc_reg_id_i;
    logic [AW-1:0][ADDR_WIDTH-1:0]        alloc_pc_i;
    logic [AW-1:0]                        alloc_excp_i;
    excpt_cause_t [AW-1:0]                alloc_excp_cause_i;
    logic [AW-1:0][ADDR_WIDTH-1:0]        alloc_excp_tval_i;
    logic [AW-1:0][EW-1:0]                alloc_idx_o;
    logic [PW-1:0]                        cpl_valid_i;
    logic [PW-1:0][EW-1:0]                cpl_idx_i;
    logic [PW-1:0][DATA_WIDTH-1:0]        cpl_data_i;
    logic [PW-1:0]                        cpl_excp_i;
    excpt_cause_t [PW-1:0]                cpl_excp_cause_i;
    logic [PW-1:0][ADDR_WIDTH-1:0]        cpl_excp_tval_i;
    logic [CW-1:0]                        commit_valid_o;
    logic [CW-1:0]                        commit_is_wb_o;
    logic [CW-1:0][REGISTER_WIDTH-1:0]    commit_reg_id_o;
    logic [CW-1:0][DATA_WIDTH-1:0]        commit_data_o;
    logic [CW-1:0][ADDR_WIDTH-1:0]        commit_pc_o;
    logic                                 excp_we_o;
    excpt_cause_t                         excp_cause_o;
    logic [ADDR_WIDTH-1:0]                excp_pc_o;
    logic [ADDR_WIDTH-1:0]                excp_tval_o;
    logic                                 flush_o;
    logic [EW:0]                          count_o;
    logic                                 empty_o;
`ifdef ROB_BRANCH_FLUSH_EN
    logic                                 bflush_valid_i;
    logic [EW-1:0]                        bflush_idx_i;
`endif

    int n_tests;
    int n_fail;

    reorder_buffer_mw #(
        .ROB_ENTRIES  (N),
        .ALLOC_WIDTH  (AW),
        .COMMIT_WIDTH (CW),
        .CPL_PORTS    (PW)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .alloc_valid_i      (alloc_valid_i),
        .alloc_ready_o      (alloc_ready_o),
        .alloc_is_wb_i      (alloc_is_wb_i),
        .alloc_reg_id_i     (alloc_reg_id_i),
        .alloc_pc_i         (alloc_pc_i),
        .alloc_excp_i       (alloc_excp_i),
        .alloc_excp_cause_i (alloc_excp_cause_i),
        .alloc_excp_tval_i  (alloc_excp_tval_i),
        .alloc_idx_o        (alloc_idx_o),
        .cpl_valid_i        (cpl_valid_i),
        .cpl_idx_i          (cpl_idx_i),
        .cpl_data_i         (cpl_data_i),
        .cpl_excp_i         (cpl_excp_i),
        .cpl_excp_cause_i   (cpl_excp_cause_i),
        .cpl_excp_tval_i    (cpl_excp_tval_i),
`ifdef ROB_BRANCH_FLUSH_EN
        .bflush_valid_i     (bflush_valid_i),
        .bflush_idx_i       (bflush_idx_i),
`endif
        .commit_valid_o     (commit_valid_o),
        .commit_is_wb_o     (commit_is_wb_o),
        .commit_reg_id_o    (commit_reg_id_o),
        .commit_data_o      (commit_data_o),
        .commit_pc_o        (commit_pc_o),
        .excp_we_o          (excp_we_o),
        .excp_cause_o       (excp_cause_o),
        .excp_pc_o          (excp_pc_o),
        .excp_tval_o        (excp_tval_o),
        .flush_o            (flush_o),
        .count_o            (count_o),
        .empty_o            (empty_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        alloc_valid_i      = '0;
        alloc_is_wb_i      = '0;
        alloc_reg_id_i     = '0;
        alloc_pc_i         = '0;
        alloc_excp_i       = '0;
        alloc_excp_cause_i = {excpt_cause_t'(4'd0), excpt_cause_t'(4'd0)};
        alloc_excp_tval_i  = '0;
        cpl_valid_i        = '0;
        cpl_idx_i          = '0;
        cpl_data_i         = '0;
        cpl_excp_i         = '0;
        cpl_excp_cause_i   = {excpt_cause_t'(4'd0), excpt_cause_t'(4'd0)};
        cpl_excp_tval_i    = '0;
`ifdef ROB_BRANCH_FLUSH_EN
        bflush_valid_i     = 1'b0;
        bflush_idx_i       = '0;
`endif
    endtask

    // Two-lane dispatch with PCs pc0, pc0+4; reg_id is the PC word index.
    task automatic set_alloc2(input logic [31:0] pc0);
        alloc_valid_i     = 2'b11;
        alloc_is_wb_i     = 2'b11;
        alloc_pc_i[0]     = pc0;
        alloc_pc_i[1]     = pc0 + 32'd4;
        alloc_reg_id_i[0] = pc0[6:2];
        alloc_reg_id_i[1] = pc0[6:2] + 5'd1;
    endtask

    task automatic set_cpl(input int p, input logic [EW-1:0] idx, input logic [31:0] data,
                           input logic ex, input logic [31:0] tval);
        cpl_valid_i[p]      = 1'b1;
        cpl_idx_i[p]        = idx;
        cpl_data_i[p]       = data;
        cpl_excp_i[p]       = ex;
        cpl_excp_cause_i[p] = ex ? excpt_cause_t'(4'd2) : excpt_cause_t'(4'd0);
        cpl_excp_tval_i[p]  = tval;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        rst_i = 1'b0;
        repeat (2) tick();
        rst_i = 1'b1;
        tick();

        check_eq("rst_count", 64'(count_o), 64'd0);
        check_eq("rst_empty", 64'(empty_o), 64'd1);
        check_eq("rst_ready", 64'(alloc_ready_o), 64'd1);
        check_eq("rst_commit", 64'(commit_valid_o), 64'd0);
        check_eq("rst_flush", 64'(flush_o), 64'd0);
        check_eq("rst_idx0", 64'(alloc_idx_o[0]), 64'd0);

        // Fill all 8 slots.
        for (int c = 0; c < 4; c++) begin
            set_alloc2(32'(c * 8));
            check_eq("fill_idx0", 64'(alloc_idx_o[0]), 64'(2 * c));
            check_eq("fill_idx1", 64'(alloc_idx_o[1]), 64'(2 * c + 1));
            tick();
        end
        idle();
        check_eq("full_count", 64'(count_o), 64'd8);
        check_eq("full_ready", 64'(alloc_ready_o), 64'd0);

        // Complete pairs; each pair retires one cycle after its completion.
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                check_eq("fill_cv", 64'(commit_valid_o), 64'd3);
                check_eq("fill_pc0", 64'(commit_pc_o[0]), 64'((c - 1) * 8));
                check_eq("fill_pc1", 64'(commit_pc_o[1]), 64'((c - 1) * 8 + 4));
                check_eq("fill_data1", 64'(commit_data_o[1]), 64'(32'h100 + 2 * (c - 1) + 1));
                check_eq("fill_reg0", 64'(commit_reg_id_o[0]), 64'(2 * (c - 1)));
            end else begin
                check_eq("fill_nocommit", 64'(commit_valid_o), 64'd0);
            end
            if (c == 1) check_eq("full_commit_ready", 64'(alloc_ready_o), 64'd0);
            idle();
            if (c < 4) begin
                set_cpl(0, 3'(2 * c), 32'h100 + 32'(2 * c), 1'b0, 32'd0);
                set_cpl(1, 3'(2 * c + 1), 32'h100 + 32'(2 * c + 1), 1'b0, 32'd0);
            end
            tick();
        end
        idle();
        check_eq("drain_empty", 64'(empty_o), 64'd1);
        check_eq("drain_count", 64'(count_o), 64'd0);

        // Out-of-order completion: younger done first must not retire alone.
        set_alloc2(32'h40);
        check_eq("ooo_idx0", 64'(alloc_idx_o[0]), 64'd0);
        tick();
        idle();
        set_cpl(0, 3'd1, 32'h201, 1'b0, 32'd0);
        tick();
        idle();
        check_eq("ooo_hold", 64'(commit_valid_o), 64'd0);
        set_cpl(1, 3'd0, 32'h200, 1'b0, 32'd0);
        tick();
        idle();
        check_eq("ooo_cv", 64'(commit_valid_o), 64'd3);
        check_eq("ooo_pc0", 64'(commit_pc_o[0]), 64'h40);
        check_eq("ooo_pc1", 64'(commit_pc_o[1]), 64'h44);
        check_eq("ooo_data0", 64'(commit_data_o[0]), 64'h200);
        check_eq("ooo_data1", 64'(commit_data_o[1]), 64'h201);
        tick();
        check_eq("ooo_empty", 64'(empty_o), 64'd1);

        // Execution exception at the younger of two entries.
        set_alloc2(32'h80);
        check_eq("exc_idx0", 64'(alloc_idx_o[0]), 64'd2);
        check_eq("exc_idx1", 64'(alloc_idx_o[1]), 64'd3);
        tick();
        idle();
        set_cpl(0, 3'd2, 32'h300, 1'b0, 32'd0);
        set_cpl(1, 3'd3, 32'h0, 1'b1, 32'hDEAD);
        tick();
        idle();
        check_eq("exc_cv", 64'(commit_valid_o), 64'd1);
        check_eq("exc_pc0", 64'(commit_pc_o[0]), 64'h80);
        check_eq("exc_we_early", 64'(excp_we_o), 64'd0);
        tick();
        check_eq("exc_we", 64'(excp_we_o), 64'd1);
        check_eq("exc_flush", 64'(flush_o), 64'd1);
        check_eq("exc_pc", 64'(excp_pc_o), 64'h84);
        check_eq("exc_cause", 64'(excp_cause_o), 64'd2);
        check_eq("exc_tval", 64'(excp_tval_o), 64'hDEAD);
        check_eq("exc_cv_none", 64'(commit_valid_o), 64'd0);
        check_eq("exc_ready", 64'(alloc_ready_o), 64'd0);
        tick();
        check_eq("exc_count", 64'(count_o), 64'd0);
        check_eq("exc_flush_off", 64'(flush_o), 64'd0);
        check_eq("exc_tail", 64'(alloc_idx_o[0]), 64'd0);

        // Stale completion into a flushed slot.
        set_cpl(0, 3'd3, 32'h999, 1'b0, 32'd0);
        tick();
        idle();
        check_eq("stale_cv", 64'(commit_valid_o), 64'd0);
        check_eq("stale_count", 64'(count_o), 64'd0);
        check_eq("stale_empty", 64'(empty_o), 64'd1);

        // Advance head to 6, then exercise the wrap.
        for (int c = 0; c < 3; c++) begin
            set_alloc2(32'h0);
            tick();
        end
        idle();
        for (int c = 0; c < 4; c++) begin
            idle();
            if (c < 3) begin
                set_cpl(0, 3'(2 * c), 32'd0, 1'b0, 32'd0);
                set_cpl(1, 3'(2 * c + 1), 32'd0, 1'b0, 32'd0);
            end
            tick();
        end
        idle();
        check_eq("wrap_pre_count", 64'(count_o), 64'd0);
        check_eq("wrap_pre_tail", 64'(alloc_idx_o[0]), 64'd6);
        set_alloc2(32'hC0);
        tick();
        set_alloc2(32'hC8);
        check_eq("wrap_idx0", 64'(alloc_idx_o[0]), 64'd0);
        check_eq("wrap_idx1", 64'(alloc_idx_o[1]), 64'd1);
        tick();
        idle();
        check_eq("wrap_count", 64'(count_o), 64'd4);
        set_cpl(0, 3'd6, 32'h600, 1'b0, 32'd0);
        set_cpl(1, 3'd7, 32'h700, 1'b0, 32'd0);
        tick();
        idle();
        check_eq("wrap_cv_a", 64'(commit_valid_o), 64'd3);
        check_eq("wrap_pc_a0", 64'(commit_pc_o[0]), 64'hC0);
        check_eq("wrap_data_a1", 64'(commit_data_o[1]), 64'h700);
        set_cpl(0, 3'd0, 32'h800, 1'b0, 32'd0);
        set_cpl(1, 3'd1, 32'h900, 1'b0, 32'd0);
        tick();
        idle();
        check_eq("wrap_cv_b", 64'(commit_valid_o), 64'd3);
        check_eq("wrap_pc_b0", 64'(commit_pc_o[0]), 64'hC8);
        check_eq("wrap_pc_b1", 64'(commit_pc_o[1]), 64'hCC);
        check_eq("wrap_data_b0", 64'(commit_data_o[0]), 64'h800);
        tick();
        check_eq("wrap_empty", 64'(empty_o), 64'd1);
        check_eq("wrap_tail", 64'(alloc_idx_o[0]), 64'd2);

`ifdef ROB_BRANCH_FLUSH_EN
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            set_alloc2(32'h100 + 32'(c * 8));
            tick();
        end
        idle();
        check_eq("bf_pre_count", 64'(count_o), 64'd6);
        bflush_valid_i = 1'b1;
        bflush_idx_i   = 3'd2;
        set_alloc2(32'h180);
        tick();
        idle();
        check_eq("bf_count", 64'(count_o), 64'd3);
        check_eq("bf_tail", 64'(alloc_idx_o[0]), 64'd3);
        check_eq("bf_flush", 64'(flush_o), 64'd0);
`endif

        // Reset asserted mid-operation clears state without a clock edge.
        set_alloc2(32'h20);
        tick();
        idle();
        check_eq("mid_pre_count", 64'(count_o) != 64'd0 ? 64'd1 : 64'd0, 64'd1);
        rst_i = 1'b0;
        #1;
        check_eq("mid_rst_count", 64'(count_o), 64'd0);
        check_eq("mid_rst_empty", 64'(empty_o), 64'd1);
        check_eq("mid_rst_ready", 64'(alloc_ready_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reorder_buffer_mw.md
Name: reorder_buffer_mw

Overview:
- Multi-wide, parametrised reorder buffer for the out-of-order core. Sits between rename/dispatch and architectural register-file writeback.
- Allocates up to ALLOC_WIDTH instructions per cycle and accepts up to CPL_PORTS completions per cycle.
- Retires up to COMMIT_WIDTH instructions per cycle in program order. Precise exceptions flush everything.
- Uses an occupancy counter, so all ROB_ENTRIES slots are usable.

Parameters:
- ROB_ENTRIES, 16, entry count; power of two, >= 4.
- ROB_ENTRY_WIDTH, $clog2(ROB_ENTRIES), index width.
- ALLOC_WIDTH, 2, dispatch lanes.
- COMMIT_WIDTH, 2, retire lanes.
- CPL_PORTS, 2, completion/writeback ports.
- REGISTER_WIDTH, DATA_WIDTH, ADDR_WIDTH, params_pkg defaults, field widths.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- alloc_valid_i  in  [ALLOC_WIDTH]  lane valid; must be contiguous from lane 0
- alloc_ready_o  out  1  all lanes may allocate this cycle
- alloc_is_wb_i  in  [ALLOC_WIDTH]  lane writes a GPR
- alloc_reg_id_i  in  [ALLOC_WIDTH][REGISTER_WIDTH]  destination register
- alloc_pc_i  in  [ALLOC_WIDTH][ADDR_WIDTH]  PC
- alloc_excp_i  in  [ALLOC_WIDTH]  exception detected at decode
- alloc_excp_cause_i  in  [ALLOC_WIDTH] excpt_cause_t  cause
- alloc_excp_tval_i  in  [ALLOC_WIDTH][ADDR_WIDTH]  tval
- alloc_idx_o  out  [ALLOC_WIDTH][ROB_ENTRY_WIDTH]  slot assigned per lane
- cpl_valid_i  in  [CPL_PORTS]  completion valid
- cpl_idx_i  in  [CPL_PORTS][ROB_ENTRY_WIDTH]  completing slot
- cpl_data_i  in  [CPL_PORTS][DATA_WIDTH]  result
- cpl_excp_i, cpl_excp_cause_i, cpl_excp_tval_i  in  per port  execution exception
- commit_valid_o  out  [COMMIT_WIDTH]  lane retires
- commit_is_wb_o, commit_reg_id_o, commit_data_o, commit_pc_o  out  per lane  retired fields
- excp_we_o  out  1  exception taken
- excp_cause_o, excp_pc_o, excp_tval_o  out  exception info for the CSR file
- flush_o  out  1  pipeline flush
- count_o  out  [ROB_ENTRY_WIDTH+1]  occupancy
- empty_o  out  1  count_o == 0

Behaviour:
- Reset (async on rst_i low): head, tail, count = 0; all entry busy/done/excp bits = 0. All outputs 0, except alloc_ready_o = 1 and empty_o = 1.
- Per-entry state: busy, done, excp, wb, reg_id, data, pc, cause, tval.
- Allocation:
  - alloc_ready_o = (ROB_ENTRIES - count_q >= ALLOC_WIDTH) && !flush_o. It is computed from registered count only; same-cycle commits do not free space.
  - alloc_idx_o[i] = (tail_q + i) mod ROB_ENTRIES, always driven.
  - When ready, every valid lane i writes slot tail+i with busy=1, and done=excp=alloc_excp_i.
  - tail advances by the number of valid lanes, wrapping mod ROB_ENTRIES. If not ready, nothing is written.
  - A non-contiguous alloc_valid_i is illegal (assertion).
- Completion:
  - A valid port writes data, sets done=1, and sets excp=cpl_excp_i at cpl_idx_i.
  - It is ignored if the slot is not busy (stale after a flush).
  - Two ports naming the same slot: the higher-numbered port wins.
  - The result is visible to commit the next cycle; minimum completion-to-commit latency is 1 cycle.
- Commit:
  - Outputs are combinational from registered state.
  - Lane k commits slot head+k iff k < count_q, the slot is done and not excp, and lanes 0..k-1 commit.
  - Committed slots clear busy; head and count update by the commit count.
- Exception:
  - If slot head is busy, done and excp: no lanes commit. excp_we_o=1, flush_o=1, and excp_cause/pc/tval come from that slot.
  - An excepting slot at head+k (k>0) stops commit at lane k; it is reported once it reaches head.
- Flush:
  - Next state: head=tail=0 and count=0, and all busy/done/excp bits cleared.
  - Allocation and completion in the same cycle are discarded.
- Count: count_d = count_q + n_alloc - n_commit, range 0..ROB_ENTRIES. Full is count==ROB_ENTRIES; there is no lost slot.
- Simultaneous alloc and commit at full or empty is legal, subject to the ready rule above.
- Reset asserted mid-operation discards all contents immediately.

Optional Feature:
- Macro: ROB_BRANCH_FLUSH_EN.
- Defined:
  - Adds ports bflush_valid_i (1) and bflush_idx_i (ROB_ENTRY_WIDTH) for branch mispredicts.
  - Entries strictly younger than bflush_idx_i are squashed (busy=0): tail_d = bflush_idx_i+1, and count_d = (bflush_idx_i - head_q + 1) mod ROB_ENTRIES, minus commits this cycle.
  - Allocation is dropped that cycle. Older entries and same-cycle commits proceed.
  - An exception flush takes priority.
  - flush_o is not asserted; the front end handles the redirect.
- Undefined: these ports are absent, and only exceptions flush.

Decomposition:
- params_pkg gains ROB_ALLOC_WIDTH, ROB_COMMIT_WIDTH and ROB_CPL_PORTS defaults, plus rob_entry_t.
- excpt_cause_t is reused.
- One natural sub-module, rob_commit_sel: combinational per-lane commit-eligibility prefix chain and exception detect.

Test Plan (ROB_ENTRIES=8, widths 2):
- Fill: 4 cycles of 2-lane alloc -> alloc_idx_o {0,1},{2,3},{4,5},{6,7}; count_o=8, alloc_ready_o=0. Complete all 8 -> next cycles commit 2/cycle in order (PC 0x0..0x1C), empty_o=1 after 4 commit cycles.
- Out-of-order completion: complete slot 1 before slot 0 -> no commit. Complete slot 0 -> both commit in the next cycle, lane0=slot0, lane1=slot1.
- Exception at slot 1: slot0 done, slot1 cpl_excp_i with cause=2 and tval=0xDEAD -> lane0 commits slot0 only. Next cycle excp_we_o=1, flush_o=1, excp_pc_o=slot1 PC. Then count_o=0.
- Wrap-around: head=6 with 2 entries; allocate 2 -> idx {0,1}. Completions and commits proceed across the wrap correctly.
- Stale completion after a flush to slot 3 -> ignored, entry not busy, no commit.
- ROB_BRANCH_FLUSH_EN: head=0, count=6, bflush_idx_i=2 -> count_o=3, tail=3. The next allocation gets idx 3.
